// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared constants and types for the rv32i memory stage.
// Holds the FSM state encoding, funct3 codes, memory width codes and
// exception codes used by the LSU, its interface and the testbench.
package load_store_unit_pkg;

    // Exception codes shared with the data-memory access block
    localparam int EXCEPTION_LEN = 4;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;

    // Access width codes understood by the data-memory access block
    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

    // Load funct3 codes
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // LSU controller states
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    // True for funct3 values that encode a real load
    function automatic logic load_funct3_legal(input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for funct3 values that encode a real store
    function automatic logic store_funct3_legal(input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the execute request, writeback response and
// data-memory request channels of the LSU. The slave modport is the LSU's
// view; the master modport is the surrounding pipeline/memory view.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // Execute -> LSU request
    logic                     req_valid_In;
    logic                     req_ready_Out;
    logic [31:0]              req_addr_In;
    logic [31:0]              req_storeData_In;
    logic [2:0]               req_funct3_In;
    logic                     req_isLoad_In;
    logic                     req_isStore_In;
    logic [4:0]               req_rd_In;

    // LSU -> writeback response
    logic                     resp_valid_Out;
    logic                     resp_ready_In;
    logic [31:0]              resp_data_Out;
    logic [4:0]               resp_rd_Out;
    logic [EXCEPTION_LEN-1:0] resp_exception_Out;
    logic [31:0]              resp_badAddr_Out;

    // LSU <-> data-memory access block
    logic [31:0]              mem_addr_Out;
    logic [31:0]              mem_data_Out;
    logic [1:0]               mem_dataWidth_Out;
    logic                     mem_isRead_Out;
    logic                     mem_inputValid_Out;
    logic [EXCEPTION_LEN-1:0] mem_exception_In;
    logic [31:0]              mem_data_In;
    logic                     mem_operationOK_In;

    modport slave (
        input  req_valid_In, req_addr_In, req_storeData_In, req_funct3_In,
               req_isLoad_In, req_isStore_In, req_rd_In,
        output req_ready_Out,
        input  resp_ready_In,
        output resp_valid_Out, resp_data_Out, resp_rd_Out,
               resp_exception_Out, resp_badAddr_Out,
        output mem_addr_Out, mem_data_Out, mem_dataWidth_Out,
               mem_isRead_Out, mem_inputValid_Out,
        input  mem_exception_In, mem_data_In, mem_operationOK_In
    );

    modport master (
        output req_valid_In, req_addr_In, req_storeData_In, req_funct3_In,
               req_isLoad_In, req_isStore_In, req_rd_In,
        input  req_ready_Out,
        output resp_ready_In,
        input  resp_valid_Out, resp_data_Out, resp_rd_Out,
               resp_exception_Out, resp_badAddr_Out,
        input  mem_addr_Out, mem_data_Out, mem_dataWidth_Out,
               mem_isRead_Out, mem_inputValid_Out,
        output mem_exception_In, mem_data_In, mem_operationOK_In
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// lsu_load_extend: purely combinational sign/zero extension of right-aligned
// load data according to the load funct3.
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    // Select the extension matching the load width and signedness
    always_comb begin
        o_data = i_raw;
        case (i_funct3)
            FUNCT3_LB:  o_data = {{24{i_raw[7]}},  i_raw[7:0]};
            FUNCT3_LBU: o_data = {24'h000000,      i_raw[7:0]};
            FUNCT3_LH:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            FUNCT3_LHU: o_data = {16'h0000,        i_raw[15:0]};
            FUNCT3_LW:  o_data = i_raw;
            default:    o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: rv32i memory-stage controller. Accepts one request from
// execute, drives a level-stable request to the data-memory block, extends
// load data and returns a registered writeback response.
// Optional feature: define LSU_TIMEOUT_EN to add an ACCESS watchdog that
// faults the access after TIMEOUT_CYCLES cycles without OK or exception.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    lsu_state_t               r_state, w_state_next;

    // Request fields captured at acceptance; the memory request is driven
    // only from these so it stays stable across the whole access.
    logic [31:0]              r_addr, w_addr_next;
    logic [31:0]              r_store_data, w_store_data_next;
    logic [2:0]               r_funct3, w_funct3_next;
    logic                     r_is_load, w_is_load_next;
    logic                     r_is_store, w_is_store_next;
    logic [4:0]               r_rd, w_rd_next;

    // Registered writeback response
    logic [31:0]              r_resp_data, w_resp_data_next;
    logic [EXCEPTION_LEN-1:0] r_resp_exc, w_resp_exc_next;
    logic [31:0]              r_resp_bad, w_resp_bad_next;

    logic [31:0]              w_ext_data;
    logic [1:0]               w_mem_width;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]         r_cnt, w_cnt_next;
    logic                     w_timeout;
    // The counter holds the number of ACCESS cycles already completed, so
    // the last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    lsu_load_extend u_load_extend (
        .i_funct3 (r_funct3),
        .i_raw    (bus.mem_data_In),
        .o_data   (w_ext_data)
    );

    // Map funct3[1:0] onto the memory width code
    always_comb begin
        w_mem_width = MEM_WIDTH_WORD;
        case (r_funct3[1:0])
            2'b00:   w_mem_width = MEM_WIDTH_BYTE;
            2'b01:   w_mem_width = MEM_WIDTH_HALF;
            default: w_mem_width = MEM_WIDTH_WORD;
        endcase
    end

    // Next-state and capture logic for the IDLE/ACCESS/RESP controller
    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_store_data_next = r_store_data;
        w_funct3_next     = r_funct3;
        w_is_load_next    = r_is_load;
        w_is_store_next   = r_is_store;
        w_rd_next         = r_rd;
        w_resp_data_next  = r_resp_data;
        w_resp_exc_next   = r_resp_exc;
        w_resp_bad_next   = r_resp_bad;
`ifdef LSU_TIMEOUT_EN
        w_cnt_next        = r_cnt;
`endif

        case (r_state)
            LSU_IDLE: begin
                if (bus.req_valid_In) begin
                    w_addr_next       = bus.req_addr_In;
                    w_store_data_next = bus.req_storeData_In;
                    w_funct3_next     = bus.req_funct3_In;
                    w_is_load_next    = bus.req_isLoad_In;
                    w_is_store_next   = bus.req_isStore_In;
                    w_rd_next         = bus.req_rd_In;
                    if (!bus.req_isLoad_In && !bus.req_isStore_In) begin
                        // Pass-through: the ALU result is the writeback value
                        w_resp_data_next = bus.req_addr_In;
                        w_resp_exc_next  = EXCEP_OK;
                        w_resp_bad_next  = 32'h0;
                        w_state_next     = LSU_RESP;
                    end else if (bus.req_isLoad_In && !load_funct3_legal(bus.req_funct3_In)) begin
                        w_resp_data_next = 32'h0;
                        w_resp_exc_next  = EXCEP_INVALID_MEM_READ;
                        w_resp_bad_next  = bus.req_addr_In;
                        w_state_next     = LSU_RESP;
                    end else if (!bus.req_isLoad_In && !store_funct3_legal(bus.req_funct3_In)) begin
                        w_resp_data_next = 32'h0;
                        w_resp_exc_next  = EXCEP_INVALID_MEM_WRITE;
                        w_resp_bad_next  = bus.req_addr_In;
                        w_state_next     = LSU_RESP;
                    end else begin
                        w_state_next     = LSU_ACCESS;
`ifdef LSU_TIMEOUT_EN
                        w_cnt_next       = '0;
`endif
                    end
                end
            end

            LSU_ACCESS: begin
                // A memory exception outranks a simultaneous OK
                if (bus.mem_exception_In != EXCEP_OK) begin
                    w_resp_data_next = 32'h0;
                    w_resp_exc_next  = bus.mem_exception_In;
                    w_resp_bad_next  = r_addr;
                    w_state_next     = LSU_RESP;
                end else if (bus.mem_operationOK_In) begin
                    w_resp_data_next = r_is_load ? w_ext_data : 32'h0;
                    w_resp_exc_next  = EXCEP_OK;
                    w_resp_bad_next  = 32'h0;
                    w_state_next     = LSU_RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (w_timeout) begin
                    w_resp_data_next = 32'h0;
                    w_resp_exc_next  = r_is_load ? EXCEP_INVALID_MEM_READ
                                                 : EXCEP_INVALID_MEM_WRITE;
                    w_resp_bad_next  = r_addr;
                    w_state_next     = LSU_RESP;
                end else begin
                    w_cnt_next       = r_cnt + 1'b1;
                end
`endif
            end

            LSU_RESP: begin
                if (bus.resp_ready_In) begin
                    w_state_next = LSU_IDLE;
                end
            end

            default: begin
                w_state_next = LSU_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LSU_IDLE;
            r_addr       <= 32'h0;
            r_store_data <= 32'h0;
            r_funct3     <= 3'b000;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_rd         <= 5'd0;
            r_resp_data  <= 32'h0;
            r_resp_exc   <= EXCEP_OK;
            r_resp_bad   <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_store_data <= w_store_data_next;
            r_funct3     <= w_funct3_next;
            r_is_load    <= w_is_load_next;
            r_is_store   <= w_is_store_next;
            r_rd         <= w_rd_next;
            r_resp_data  <= w_resp_data_next;
            r_resp_exc   <= w_resp_exc_next;
            r_resp_bad   <= w_resp_bad_next;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= w_cnt_next;
`endif
        end
    end

    // Handshake outputs follow the state; data outputs come from registers
    assign bus.req_ready_Out      = (r_state == LSU_IDLE);
    assign bus.resp_valid_Out     = (r_state == LSU_RESP);
    assign bus.resp_data_Out      = r_resp_data;
    assign bus.resp_rd_Out        = r_rd;
    assign bus.resp_exception_Out = r_resp_exc;
    assign bus.resp_badAddr_Out   = r_resp_bad;

    assign bus.mem_inputValid_Out = (r_state == LSU_ACCESS);
    assign bus.mem_addr_Out       = r_addr;
    assign bus.mem_data_Out       = r_store_data;
    assign bus.mem_dataWidth_Out  = w_mem_width;
    // Loads are flagged read; a request flagged both ways is treated as a load
    assign bus.mem_isRead_Out     = r_is_load | ~r_is_store;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit.
// Expected responses are queued when a request is issued and popped when
// the unit presents resp_valid.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]              data;
        logic [4:0]               rd;
        logic [EXCEPTION_LEN-1:0] exc;
        logic [31:0]              bad;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [4:0] rd,
                            input logic [EXCEPTION_LEN-1:0] exc, input logic [31:0] bad);
        exp_t e;
        e.data = data;
        e.rd   = rd;
        e.exc  = exc;
        e.bad  = bad;
        sb_q.push_back(e);
    endtask

    // Present one request for a single accepting edge, then scramble the
    // request inputs so the unit must rely on its captured copy.
    task automatic issue(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd);
        bus.req_addr_In      = addr;
        bus.req_storeData_In = sd;
        bus.req_funct3_In    = f3;
        bus.req_isLoad_In    = ld;
        bus.req_isStore_In   = st;
        bus.req_rd_In        = rd;
        bus.req_valid_In     = 1'b1;
        tick();
        bus.req_valid_In     = 1'b0;
        bus.req_addr_In      = 32'hFFFF_FFFF;
        bus.req_storeData_In = 32'h5555_AAAA;
        bus.req_funct3_In    = 3'b111;
        bus.req_rd_In        = 5'd31;
    endtask

    // Wait (bounded) for a response, compare with the scoreboard, accept it
    task automatic take_resp(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (bus.resp_valid_Out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_resp_valid"}, 32'(bus.resp_valid_Out), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_data"}, bus.resp_data_Out, e.data);
            check({tag, "_rd"},   32'(bus.resp_rd_Out), 32'(e.rd));
            check({tag, "_exc"},  32'(bus.resp_exception_Out), 32'(e.exc));
            check({tag, "_bad"},  bus.resp_badAddr_Out, e.bad);
            $display("resp %-12s data=%h rd=%0d exc=%0d bad=%h", tag, bus.resp_data_Out,
                     bus.resp_rd_Out, bus.resp_exception_Out, bus.resp_badAddr_Out);
        end
        bus.resp_ready_In = 1'b1;
        tick();
        bus.resp_ready_In = 1'b0;
        check({tag, "_back_idle"}, 32'(bus.req_ready_Out), 32'd1);
        check({tag, "_gap_valid"}, 32'(bus.mem_inputValid_Out), 32'd0);
    endtask

    // Load completed by OK in the first ACCESS cycle
    task automatic load_ok(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [1:0] width, input logic [31:0] raw,
                           input logic [31:0] exp_data, input logic [4:0] rd);
        push_exp(exp_data, rd, EXCEP_OK, 32'h0);
        issue(addr, 32'h0, f3, 1'b1, 1'b0, rd);
        check({tag, "_mem_valid"}, 32'(bus.mem_inputValid_Out), 32'd1);
        check({tag, "_mem_addr"},  bus.mem_addr_Out, addr);
        check({tag, "_width"},     32'(bus.mem_dataWidth_Out), 32'(width));
        check({tag, "_is_read"},   32'(bus.mem_isRead_Out), 32'd1);
        bus.mem_data_In        = raw;
        bus.mem_operationOK_In = 1'b1;
        tick();
        bus.mem_operationOK_In = 1'b0;
        bus.mem_data_In        = 32'h0;
        check({tag, "_latency"}, 32'(bus.resp_valid_Out), 32'd1);
        take_resp(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        bus.req_valid_In       = 1'b0;
        bus.req_addr_In        = 32'h0;
        bus.req_storeData_In   = 32'h0;
        bus.req_funct3_In      = 3'b000;
        bus.req_isLoad_In      = 1'b0;
        bus.req_isStore_In     = 1'b0;
        bus.req_rd_In          = 5'd0;
        bus.resp_ready_In      = 1'b0;
        bus.mem_exception_In   = EXCEP_OK;
        bus.mem_data_In        = 32'h0;
        bus.mem_operationOK_In = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready",  32'(bus.req_ready_Out), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid_Out), 32'd0);
        check("rst_mem_valid",  32'(bus.mem_inputValid_Out), 32'd0);
        check("rst_resp_data",  bus.resp_data_Out, 32'h0);
        check("rst_bad_addr",   bus.resp_badAddr_Out, 32'h0);
        check("rst_mem_addr",   bus.mem_addr_Out, 32'h0);

        // Load extension variants
        load_ok("lb",  32'h4000_0003, FUNCT3_LB,  MEM_WIDTH_BYTE, 32'h0000_0080, 32'hFFFF_FF80, 5'd1);
        load_ok("lbu", 32'h4000_0003, FUNCT3_LBU, MEM_WIDTH_BYTE, 32'h0000_0080, 32'h0000_0080, 5'd2);
        load_ok("lh",  32'h4000_0010, FUNCT3_LH,  MEM_WIDTH_HALF, 32'h1234_8001, 32'hFFFF_8001, 5'd3);
        load_ok("lhu", 32'h4000_0010, FUNCT3_LHU, MEM_WIDTH_HALF, 32'h1234_8001, 32'h0000_8001, 5'd4);
        load_ok("lw",  32'h4000_0020, FUNCT3_LW,  MEM_WIDTH_WORD, 32'h89AB_CDEF, 32'h89AB_CDEF, 5'd5);

        // SW to the IO word with OK one cycle late
        push_exp(32'h0, 5'd0, EXCEP_OK, 32'h0);
        issue(32'h6000_0000, 32'hDEAD_BEEF, FUNCT3_SW, 1'b0, 1'b1, 5'd0);
        check("sw_valid_c1", 32'(bus.mem_inputValid_Out), 32'd1);
        check("sw_width",    32'(bus.mem_dataWidth_Out), 32'(MEM_WIDTH_WORD));
        check("sw_is_read",  32'(bus.mem_isRead_Out), 32'd0);
        check("sw_mem_data", bus.mem_data_Out, 32'hDEAD_BEEF);
        tick();
        check("sw_valid_c2", 32'(bus.mem_inputValid_Out), 32'd1);
        check("sw_addr_c2",  bus.mem_addr_Out, 32'h6000_0000);
        check("sw_data_c2",  bus.mem_data_Out, 32'hDEAD_BEEF);
        bus.mem_operationOK_In = 1'b1;
        tick();
        bus.mem_operationOK_In = 1'b0;
        check("sw_valid_off", 32'(bus.mem_inputValid_Out), 32'd0);
        take_resp("sw");

        // SH width decode
        push_exp(32'h0, 5'd9, EXCEP_OK, 32'h0);
        issue(32'h4000_0100, 32'h0000_BEEF, FUNCT3_SH, 1'b0, 1'b1, 5'd9);
        check("sh_width", 32'(bus.mem_dataWidth_Out), 32'(MEM_WIDTH_HALF));
        bus.mem_operationOK_In = 1'b1;
        tick();
        bus.mem_operationOK_In = 1'b0;
        take_resp("sh");

        // LW with memory exception; simultaneous OK must be ignored
        push_exp(32'h0, 5'd3, EXCEP_INVALID_MEM_READ, 32'h4000_0002);
        issue(32'h4000_0002, 32'h0, FUNCT3_LW, 1'b1, 1'b0, 5'd3);
        check("lwx_valid", 32'(bus.mem_inputValid_Out), 32'd1);
        bus.mem_exception_In   = EXCEP_INVALID_MEM_READ;
        bus.mem_operationOK_In = 1'b1;
        bus.mem_data_In        = 32'h5555_5555;
        tick();
        bus.mem_exception_In   = EXCEP_OK;
        bus.mem_operationOK_In = 1'b0;
        bus.mem_data_In        = 32'h0;
        check("lwx_valid_once", 32'(bus.mem_inputValid_Out), 32'd0);
        check("lwx_resp_next",  32'(bus.resp_valid_Out), 32'd1);
        take_resp("lw_exc");

        // Illegal load funct3: no memory request
        push_exp(32'h0, 5'd4, EXCEP_INVALID_MEM_READ, 32'h4000_0010);
        issue(32'h4000_0010, 32'h0, 3'b011, 1'b1, 1'b0, 5'd4);
        check("ill_ld_no_mem", 32'(bus.mem_inputValid_Out), 32'd0);
        take_resp("ill_load");

        // Illegal store funct3
        push_exp(32'h0, 5'd5, EXCEP_INVALID_MEM_WRITE, 32'h4000_0020);
        issue(32'h4000_0020, 32'h1, 3'b100, 1'b0, 1'b1, 5'd5);
        check("ill_st_no_mem", 32'(bus.mem_inputValid_Out), 32'd0);
        take_resp("ill_store");

        // Pass-through op
        push_exp(32'h1234_5678, 5'd6, EXCEP_OK, 32'h0);
        issue(32'h1234_5678, 32'h0, 3'b000, 1'b0, 1'b0, 5'd6);
        check("pass_no_mem", 32'(bus.mem_inputValid_Out), 32'd0);
        take_resp("pass");

        // Writeback stall: response held stable for 5 cycles
        push_exp(32'hCAFE_F00D, 5'd7, EXCEP_OK, 32'h0);
        issue(32'hCAFE_F00D, 32'h0, 3'b000, 1'b0, 1'b0, 5'd7);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.resp_valid_Out), 32'd1);
            check("hold_data",  bus.resp_data_Out, 32'hCAFE_F00D);
            check("hold_ready", 32'(bus.req_ready_Out), 32'd0);
            tick();
        end
        take_resp("hold");

        // Reset during ACCESS drops the operation
        issue(32'h4000_0040, 32'h0, FUNCT3_LW, 1'b1, 1'b0, 5'd8);
        check("rsta_valid_before", 32'(bus.mem_inputValid_Out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsta_mem_valid",  32'(bus.mem_inputValid_Out), 32'd0);
        check("rsta_resp_valid", 32'(bus.resp_valid_Out), 32'd0);
        tick();
        check("rsta_req_ready",  32'(bus.req_ready_Out), 32'd1);
        check("rsta_no_resp",    32'(bus.resp_valid_Out), 32'd0);

        // ACCESS with neither OK nor exception
`ifdef LSU_TIMEOUT_EN
        push_exp(32'h0, 5'd10, EXCEP_INVALID_MEM_READ, 32'h4000_0100);
        issue(32'h4000_0100, 32'h0, FUNCT3_LW, 1'b1, 1'b0, 5'd10);
        n = 0;
        while (bus.mem_inputValid_Out === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("timeout_cycles", 32'(n), 32'd4);
        take_resp("timeout");
`else
        issue(32'h4000_0100, 32'h0, FUNCT3_LW, 1'b1, 1'b0, 5'd10);
        n = 0;
        repeat (1000) begin
            tick();
            n++;
        end
        check("noto_mem_valid",  32'(bus.mem_inputValid_Out), 32'd1);
        check("noto_resp_valid", 32'(bus.resp_valid_Out), 32'd0);
        $display("waited %0d cycles in ACCESS", n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
